// File: rtl/tristate_bus_pkg.sv
// ---------------------------------------------------------------------------
// tristate_bus_pkg
//
// Shared definitions for the tri-state bus port controller:
//   busState_t  - controller states (IDLE, TURN_ON, DRIVE, TURN_OFF)
//   CNT_W       - width of the shared turnaround/hold down-counter
//   reloadValue - converts a phase length in cycles into the value the
//                 down-counter is loaded with, clipped to the counter range
// ---------------------------------------------------------------------------
package tristate_bus_pkg;

    localparam int CNT_W = 4;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        TURN_ON  = 2'd1,
        DRIVE    = 2'd2,
        TURN_OFF = 2'd3
    } busState_t;

    // A phase lasting N cycles counts N-1 down to 0, so the reload value is
    // one less than the length. Zero-length phases and lengths beyond the
    // counter range are clipped so the result always fits in CNT_W bits.
    function automatic logic [CNT_W-1:0] reloadValue(input int cycles);
        int clipped;
        if (cycles <= 0) begin
            clipped = 0;
        end else if (cycles > (1 << CNT_W)) begin
            clipped = (1 << CNT_W) - 1;
        end else begin
            clipped = cycles - 1;
        end
        return clipped[CNT_W-1:0];
    endfunction

endpackage

// File: rtl/bus_turn_counter.sv
// ---------------------------------------------------------------------------
// bus_turn_counter
//
// Loadable CNT_W-bit down-counter shared by the turnaround and hold phases
// of the tri-state bus port. It stops at zero rather than wrapping, so a
// phase that is left idle at zero stays there.
//
// Ports:
//   clock      - rising-edge clock
//   reset      - synchronous active-high reset, clears the count
//   enable     - when low the count holds (clock gate)
//   load       - load loadValue instead of counting down
//   loadValue  - value loaded when load is high
//   count      - current count
//   isZero     - count is zero (final cycle of the current phase)
// ---------------------------------------------------------------------------
module bus_turn_counter
    import tristate_bus_pkg::*;
(
    input  logic             clock,
    input  logic             reset,
    input  logic             enable,
    input  logic             load,
    input  logic [CNT_W-1:0] loadValue,
    output logic [CNT_W-1:0] count,
    output logic             isZero
);

    // Count register: reset wins over the clock gate; a load wins over the
    // decrement so a phase change and the start of the next phase coincide.
    always_ff @(posedge clock) begin
        if (reset) begin
            count <= '0;
        end else if (enable) begin
            if (load) begin
                count <= loadValue;
            end else if (count != '0) begin
                count <= count - CNT_W'(1);
            end
        end
    end

    // Zero detect marks the last cycle of the phase being timed.
    assign isZero = (count == '0);

endmodule

// File: rtl/tristate_bus_port.sv
// ---------------------------------------------------------------------------
// tristate_bus_port
//
// Controller for one shared bidirectional tri-state bus. Words accepted on a
// valid/ready interface are driven onto b_bus for HOLD cycles each, with
// TURNAROUND released cycles before and after every drive burst so that
// other drivers on the net have time to let go. Back-to-back words inside a
// burst are driven with no gap. While released, the bus is sampled; while
// driving, the bus is compared against the driven word to flag contention.
//
// Parameters:
//   WIDTH       - bus and data width in bits (>= 1)
//   TURNAROUND  - released cycles before and after each burst (0..15)
//   HOLD        - cycles each word is driven (1..16)
//
// Ports:
//   i_clk        - clock, all state changes on the rising edge
//   i_rst        - synchronous active-high reset, takes priority over i_cg
//   i_cg         - clock gate, when low every register holds
//   i_wrValid    - write word offered
//   o_wrReady    - write word accepted when i_wrValid is also high
//   i_wrData     - word to drive (held stable by upstream while valid)
//   b_bus        - shared tri-state bus net
//   o_oe         - this block is driving b_bus
//   o_rdValid    - o_rdData is a fresh sample of the released bus
//   o_rdData     - registered bus sample
//   o_contention - one-cycle pulse when the driven word was not seen on the bus
// ---------------------------------------------------------------------------
module tristate_bus_port
    import tristate_bus_pkg::*;
#(
    parameter int WIDTH      = 8,
    parameter int TURNAROUND = 1,
    parameter int HOLD       = 1
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_cg,
    input  logic             i_wrValid,
    output logic             o_wrReady,
    input  logic [WIDTH-1:0] i_wrData,
    inout  tri logic [WIDTH-1:0] b_bus,
    output logic             o_oe,
    output logic             o_rdValid,
    output logic [WIDTH-1:0] o_rdData,
    output logic             o_contention
);

    // Parameter range checks, evaluated at elaboration.
    if (WIDTH < 1) begin : gBadWidth
        $error("tristate_bus_port: WIDTH must be at least 1");
    end
    if (TURNAROUND < 0 || TURNAROUND > 15) begin : gBadTurnaround
        $error("tristate_bus_port: TURNAROUND must be in 0..15");
    end
    if (HOLD < 1 || HOLD > 16) begin : gBadHold
        $error("tristate_bus_port: HOLD must be in 1..16");
    end

    localparam logic [CNT_W-1:0] TURN_RELOAD = reloadValue(TURNAROUND);
    localparam logic [CNT_W-1:0] HOLD_RELOAD = reloadValue(HOLD);
    localparam bit               NO_TURN     = (TURNAROUND == 0);

    busState_t        state;
    busState_t        nextState;
    logic [WIDTH-1:0] dataReg;
    logic             dataLoad;
    logic             cntLoad;
    logic [CNT_W-1:0] cntLoadValue;
    logic [CNT_W-1:0] cnt;
    logic             cntZero;
    logic             handshake;

    // One counter times every phase; the FSM decides when it reloads and
    // with which phase length.
    bus_turn_counter uTurnCounter (
        .clock     (i_clk),
        .reset     (i_rst),
        .enable    (i_cg),
        .load      (cntLoad),
        .loadValue (cntLoadValue),
        .count     (cnt),
        .isZero    (cntZero)
    );

    // Ready depends only on the state and the counter, never on i_wrValid.
    // It is suppressed while gated so a gated cycle cannot swallow a word,
    // and while in reset so nothing is accepted that reset would discard.
    always_comb begin
        o_wrReady = 1'b0;
        if (i_cg && !i_rst) begin
            o_wrReady = (state == IDLE) || ((state == DRIVE) && cntZero);
        end
    end

    assign handshake = i_wrValid && o_wrReady;

    // Next-state logic. Each transition into a timed phase reloads the
    // counter with that phase's length; within a phase the counter simply
    // runs down. A handshake on the final hold cycle chains the next word
    // straight into another hold period with no released gap.
    always_comb begin
        nextState    = state;
        cntLoad      = 1'b0;
        cntLoadValue = '0;
        dataLoad     = 1'b0;
        unique case (state)
            IDLE: begin
                if (handshake) begin
                    dataLoad = 1'b1;
                    cntLoad  = 1'b1;
                    if (NO_TURN) begin
                        nextState    = DRIVE;
                        cntLoadValue = HOLD_RELOAD;
                    end else begin
                        nextState    = TURN_ON;
                        cntLoadValue = TURN_RELOAD;
                    end
                end
            end
            TURN_ON: begin
                if (cntZero) begin
                    nextState    = DRIVE;
                    cntLoad      = 1'b1;
                    cntLoadValue = HOLD_RELOAD;
                end
            end
            DRIVE: begin
                if (cntZero) begin
                    if (handshake) begin
                        dataLoad     = 1'b1;
                        cntLoad      = 1'b1;
                        cntLoadValue = HOLD_RELOAD;
                    end else if (NO_TURN) begin
                        nextState = IDLE;
                    end else begin
                        nextState    = TURN_OFF;
                        cntLoad      = 1'b1;
                        cntLoadValue = TURN_RELOAD;
                    end
                end
            end
            TURN_OFF: begin
                if (cntZero) begin
                    nextState = IDLE;
                end
            end
            default: begin
                nextState = IDLE;
            end
        endcase
    end

    // State and data registers. Reset lands in IDLE from anywhere, which
    // releases the bus on the following cycle even mid-burst.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state   <= IDLE;
            dataReg <= '0;
        end else if (i_cg) begin
            state <= nextState;
            if (dataLoad) begin
                dataReg <= i_wrData;
            end
        end
    end

    // Output enable is decoded purely from the state register, so it cannot
    // glitch on input changes; while gated it holds with the state.
    assign o_oe  = (state == DRIVE);
    assign b_bus = o_oe ? dataReg : 'z;

    // Read and contention path. The bus is sampled every enabled cycle; the
    // sample is only marked valid when it was taken while idle, but the data
    // register is left as-is otherwise. The 4-state compare means undriven
    // or conflicting bits during DRIVE also count as contention.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_rdValid    <= 1'b0;
            o_rdData     <= '0;
            o_contention <= 1'b0;
        end else if (i_cg) begin
            o_rdValid    <= (state == IDLE);
            o_rdData     <= b_bus;
            o_contention <= (state == DRIVE) && (b_bus !== dataReg);
        end
    end

endmodule

// File: doc/tristate_bus_port.md
# tristate_bus_port

Synchronous controller for one shared bidirectional tri-state bus. Accepts words on a valid/ready interface and drives them onto a `tri logic` inout net, with programmable turnaround gaps on both edges of every drive burst. Samples the bus when it is released and flags contention while driving. Sits directly upstream of any module with a bidirectional `b_*` net port: it is the single on-chip driver feeding that net, and other drivers may share the net off-chip.

## Interface
- `WIDTH`, 8: bus and data width in bits, 1 or more.
- `TURNAROUND`, 1: released cycles before and after each drive burst, 0..15.
- `HOLD`, 1: cycles each word is driven, 1..16.

Ports:
- `i_clk`  input  1  clock; all state changes on rising edge.
- `i_rst`  input  1  reset; synchronous and active-high.
- `i_cg`  input  1  clock gate; when low, all registers hold.
- `i_wrValid`  input  1  write word offered.
- `o_wrReady`  output  1  write word accepted this cycle when `i_wrValid` is also high.
- `i_wrData`  input  WIDTH  word to drive.
- `b_bus`  inout tri logic  WIDTH  shared bus net.
- `o_oe`  output  1  this block is driving `b_bus`.
- `o_rdValid`  output  1  `o_rdData` holds a fresh sample of the released bus.
- `o_rdData`  output  WIDTH  registered bus sample.
- `o_contention`  output  1  one-cycle pulse when the driven value was not observed on the bus.

## Operation
- States:
  - IDLE: bus released, `o_wrReady` is 1.
  - TURN_ON: released, count down.
  - DRIVE: `o_oe` is 1, count HOLD.
  - TURN_OFF: released, count down.
- Drive assignment: `b_bus = o_oe ? dataReg : 'z`. `o_oe` is decoded only from the state register, so it is glitch-free.
- IDLE with handshake:
  - Load `dataReg`.
  - `TURNAROUND`=0: go to DRIVE. Otherwise go to TURN_ON with `cnt=TURNAROUND-1`.
- TURN_ON: decrement `cnt`. At 0, go to DRIVE with `cnt=HOLD-1`.
- DRIVE: `o_wrReady` is 1 only on the final hold cycle (`cnt==0`).
  - Handshake on that cycle: load the new word, reload `cnt=HOLD-1`, and stay in DRIVE. Back-to-back words have no gap.
  - No handshake: go to TURN_OFF (`cnt=TURNAROUND-1`), or go to IDLE if `TURNAROUND`=0.
- TURN_OFF: `o_wrReady` is 0. Decrement `cnt`. At 0, go to IDLE.
- Read path: every enabled cycle, `o_rdData <= b_bus` and `o_rdValid <= (state==IDLE)`. `o_rdData` is not cleared when invalid.
- Contention: every enabled cycle, `o_contention <= (state==DRIVE) && (b_bus !== dataReg)`. Uses 4-state case inequality, so X or Z on any bit counts as contention.
- `i_cg` low: state, `cnt`, `dataReg`, and all outputs hold. `o_wrReady` is forced to 0, so no handshake is lost. `o_oe` holds, so a burst in progress keeps driving.
- Reset in any state, including mid-DRIVE:
  - Next cycle: IDLE, `o_oe`=0, `b_bus` released.
  - Reset takes priority over `i_cg`.
  - Reset values: `dataReg`=0, `cnt`=0, `o_rdValid`=0, `o_rdData`=0, `o_contention`=0.
  - `o_wrReady` is 0 while `i_rst` is high and 1 in the first cycle after reset.

## Timing
- Handshake in IDLE at edge t: `o_oe` high for cycles t+T+1 .. t+T+H, where T=`TURNAROUND` and H=`HOLD`.
- Minimum occupancy for an isolated word: 2T+H cycles from handshake back to IDLE.
- Ready for the next isolated word at cycle t+2T+H+1.
- `o_rdData` and `o_contention` have one-cycle latency relative to the bus value sampled.
- A contention pulse lags the offending DRIVE cycle by one. The last pulse of a burst can appear in the first TURN_OFF/IDLE cycle.
- `o_wrReady` is combinational from state and `cnt` only, never from `i_wrValid`.
- Upstream must keep `i_wrData` stable while `i_wrValid` is high.

## Structure
- Package `tristate_bus_pkg` holds:
  - The state enum `busState_t` (IDLE, TURN_ON, DRIVE, TURN_OFF).
  - The constant `CNT_W`=4.
  - A function returning the clipped reload value.
- One sub-module, `bus_turn_counter`: a `CNT_W`-bit loadable down-counter with an `isZero` output and enable input, shared by the turnaround and hold phases.
- Elaboration-time checks: `TURNAROUND` ≤ 15, 1 ≤ `HOLD` ≤ 16.

## Test plan
1. Reset, then hold `i_rst` for 3 cycles with `i_wrValid`=1 → after release `o_oe`=0, `b_bus`=8'hzz, `o_wrReady`=1, `o_rdValid` goes to 1 one cycle later.
2. T=1, H=2: one word 8'hA5 with no external driver → `b_bus`=8'hA5 for exactly 2 cycles starting 2 cycles after handshake, bracketed by released cycles, and `o_contention` stays 0.
3. T=2, H=1: three words 8'h01, 8'h02, 8'h03 offered back-to-back → one TURN_ON gap, bus shows 01, 02, 03 on consecutive cycles, then 2 released cycles.
4. External driver forces bit 0 to 0 while 8'hFF is driven → `o_contention`=1 for each DRIVE cycle, delayed by one. With the external driver released to 'z while idle, `o_rdData` reads 8'hzz and `o_rdValid`=1.
5. `i_cg`=0 for 3 cycles mid-DRIVE → `o_oe` and `b_bus` hold their values, `o_wrReady`=0, and burst length is extended by 3.
6. `i_rst` asserted on the second DRIVE cycle of H=4 → bus released on the next cycle, IDLE state, and the word is not resumed.
